// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: FU count, tag width, queue depth and the DUMMY tag.
// Optional round-robin arbitration is selected with the CDB_ROUND_ROBIN_EN macro.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_NUM_FU     = 5;
  localparam int unsigned CDB_TAG_W      = 7;
  localparam int unsigned CDB_FIFO_DEPTH = 2;

  typedef logic [CDB_TAG_W-1:0] phys_reg_t;

  localparam phys_reg_t DUMMY_TAG = 7'b1111111;

  // Increment with wrap modulo m; works for non-power-of-two moduli too.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned m);
    return (v + 1 >= m) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-FU completion tag queue with push/pop/flush and a registered full flag.
// A push into an empty queue is visible on o_head in the same cycle (bypass).
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int unsigned TAG_W      = CDB_TAG_W,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [TAG_W-1:0] i_tag,
  output logic [TAG_W-1:0] o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [TAG_W-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]  r_head;
  logic [PtrW-1:0]  r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_full;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_d;

  assign o_empty = (r_count == '0);
  assign o_full  = r_full;
  assign o_count = r_count;
  assign o_head  = o_empty ? i_tag : r_mem[r_head];

  // A push while full is dropped; the registered full flag gives no credit for a same-cycle pop.
  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && (!o_empty || w_push);

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CNT_W'(1);
      2'b01:   w_count_d = r_count - CNT_W'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_tag;
        r_tail        <= PtrW'(wrap_inc(32'(r_tail), FIFO_DEPTH));
      end
      if (w_pop) begin
        r_head <= PtrW'(wrap_inc(32'(r_head), FIFO_DEPTH));
      end
      r_count <= w_count_d;
      r_full  <= (w_count_d == CNT_W'(FIFO_DEPTH));
    end
  end

  a_no_push_when_full: assert property (
    @(posedge i_clk) disable iff (i_rst || i_flush) !(i_push && r_full)
  );

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-FU tag queues feeding a one-tag-per-cycle registered broadcast.
// Fixed priority (highest index wins) by default; define CDB_ROUND_ROBIN_EN for round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU     = CDB_NUM_FU,
  parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int unsigned TAG_W      = CDB_TAG_W,
  parameter int unsigned GRANT_W    = $clog2(NUM_FU)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    branch_not_taken,
  input  logic [NUM_FU-1:0]       fu_done,
  input  logic [NUM_FU*TAG_W-1:0] fu_tag,
  output logic [NUM_FU-1:0]       fu_stall,
  output logic [TAG_W-1:0]        CDB_out,
  output logic                    CDB_valid,
  output logic [GRANT_W-1:0]      cdb_grant_idx
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_FU*TAG_W-1:0] w_head;
  logic [NUM_FU*CntW-1:0]  w_count;
  logic [NUM_FU-1:0]       w_empty;
  logic [NUM_FU-1:0]       w_req;
  logic [NUM_FU-1:0]       w_pop;
  logic                    w_any;
  logic [GRANT_W-1:0]      w_win;
  logic [TAG_W-1:0]        w_win_tag;

  logic                    r_valid;
  logic [TAG_W-1:0]        r_out;
  logic [GRANT_W-1:0]      r_grant;

  cdb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TAG_W      (TAG_W),
    .CNT_W      (CntW)
  ) u_fifo [NUM_FU-1:0] (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_flush (branch_not_taken),
    .i_push  (fu_done),
    .i_pop   (w_pop),
    .i_tag   (fu_tag),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (fu_stall),
    .o_count (w_count)
  );

  // Requesters are non-empty queues plus empty queues taking an accepted push this cycle.
  assign w_req = ~w_empty | (fu_done & ~fu_stall);
  assign w_any = |w_req;

`ifdef CDB_ROUND_ROBIN_EN
  logic [GRANT_W-1:0] r_rr;

  // Walk the search order backwards so the first requester after r_rr is the last one kept.
  always_comb begin
    int unsigned idx;
    w_win = '0;
    for (int k = NUM_FU; k >= 1; k--) begin
      idx = 32'(r_rr) + 32'(k);
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (w_req[idx]) w_win = GRANT_W'(idx);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || branch_not_taken) begin
      r_rr <= '0;
    end else if (w_any) begin
      r_rr <= w_win;
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_req[i]) w_win = GRANT_W'(i);
    end
  end
`endif

  always_comb begin
    w_pop = '0;
    if (w_any) w_pop[w_win] = 1'b1;
  end

  assign w_win_tag = w_head[32'(w_win)*TAG_W +: TAG_W];

  always_ff @(posedge clock) begin
    if (reset || branch_not_taken) begin
      r_valid <= 1'b0;
      r_out   <= '1;
      r_grant <= '0;
    end else if (w_any) begin
      r_valid <= 1'b1;
      r_out   <= w_win_tag;
      r_grant <= w_win;
    end else begin
      r_valid <= 1'b0;
      r_out   <= '1;
    end
  end

  assign CDB_valid     = r_valid;
  assign CDB_out       = r_out;
  assign cdb_grant_idx = r_grant;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_chk
    a_count_bound: assert property (
      @(posedge clock) w_count[g*CntW +: CntW] <= CntW'(FIFO_DEPTH)
    );
  end

  a_single_pop: assert property (@(posedge clock) $onehot0(w_pop));

endmodule
